ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Param PCLEN, default 32, SHALL be the width of the word-indexed PC (PC+1 = next instruction).
REQ-002 Param DEPTH, default 4, SHALL be the queue depth; legal values are 2, 4 and 8.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 pc_in  in  PCLEN  SHALL be the fetch address from the program counter.
REQ-006 pc_valid / pc_ready  in/out  1/1  SHALL form the PC request handshake; accept = both high.
REQ-007 flush  in  1  SHALL be the redirect request (branch/JAL/JALR taken).
REQ-008 mem_req / mem_addr  out  1/PCLEN  SHALL form the instruction-memory request.
REQ-009 mem_ack / mem_rdata  in  1/32  SHALL form the memory response; data is valid only while mem_ack=1.
REQ-010 instr / instr_pc  out  32/PCLEN  SHALL carry the head instruction and its PC.
REQ-011 instr_valid / instr_ready  out/in  1/1  SHALL form the decode handshake; pop = both high.
REQ-012 count  out  clog2(DEPTH)+1  SHALL give the queue occupancy.

Function
REQ-013 FSM states SHALL be IDLE (nothing outstanding), WAIT (one request outstanding) and DROP (outstanding request already flushed).
REQ-014 At most one memory request SHALL be outstanding.
REQ-015 Free slots SHALL be DEPTH - count - (state==WAIT ? 1 : 0).
REQ-016 pc_ready SHALL be 1 only when flush=0, free slots >= 1 and (state==IDLE, or state==WAIT with mem_ack=1 this cycle).
REQ-017 On accept, the block SHALL register pc_in into mem_addr, drive mem_req=1 from the next cycle and enter WAIT.
REQ-018 mem_req and mem_addr SHALL stay stable until the cycle in which mem_ack=1 is sampled; mem_req falls next cycle unless a new request was accepted in that cycle.
REQ-019 In WAIT with mem_ack=1, {mem_rdata, mem_addr} SHALL be pushed to the queue tail; state goes to IDLE, or stays WAIT on a same-cycle accept.
REQ-020 Push and pop in the same cycle SHALL both occur and leave count unchanged, including at count=DEPTH-1.
REQ-021 Queue pointers SHALL wrap modulo DEPTH.
REQ-022 instr_valid SHALL equal (count != 0), subject to REQ-031.
REQ-023 instr and instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-024 Flush SHALL set count to 0 and discard all queued entries at the end of the flush cycle.
REQ-025 Flush while in WAIT without mem_ack SHALL go to DROP.
REQ-026 Flush in WAIT with mem_ack SHALL discard that response and go to IDLE.
REQ-027 In DROP, mem_req SHALL stay high, pc_ready=0, and mem_ack SHALL discard the data and go to IDLE.
REQ-028 mem_ack seen in IDLE SHALL be ignored.
REQ-029 A pop in a flush cycle SHALL complete normally (decode sees the head); nothing is pushed.

Reset
REQ-030 On reset, the block SHALL enter IDLE with count=0, mem_req=0, mem_addr=0, instr_valid=0, pc_ready=0 during reset, and any in-flight ack ignored.

Configuration
REQ-031 With macro IFQ_BYPASS_EN defined, a response arriving while count=0 and instr_ready=1 (no flush) SHALL be presented on instr/instr_pc/instr_valid combinationally in the ack cycle and SHALL NOT be enqueued; without the macro, every response SHALL be enqueued and instr_valid SHALL rise no earlier than the next cycle.

Verification
REQ-032 Reset, then pc_in=0x10 accepted, ack after 2 cycles with rdata=0x00500093 -> instr=0x00500093, instr_pc=0x10, count=1 (bypass off).
REQ-033 instr_ready=0, stream PCs 0..7 with 1-cycle acks, DEPTH=4 -> pc_ready drops when count+outstanding=4, no entry lost or duplicated, FIFO order kept across pointer wrap.
REQ-034 Flush in WAIT (no ack), ack 3 cycles later with 0xDEADBEEF -> state DROP, data never appears, pc_ready=0 until ack, then IDLE.
REQ-035 Flush with count=3 and same-cycle mem_ack -> count=0 next cycle, response discarded, instr_valid=0.
REQ-036 Ack and new accept in the same cycle, with a simultaneous pop at count=DEPTH-1 -> count unchanged, mem_req held high, new mem_addr presented.
REQ-037 Assert reset while in WAIT, then pulse mem_ack after reset -> IDLE, mem_req=0, count=0, ack ignored.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue between the program counter and decode.
// Issues at most one instruction-memory request at a time and buffers the
// responses, each tagged with its PC, in a DEPTH-entry FIFO. A flush (redirect)
// empties the FIFO and discards any response that is still in flight.
// Optional feature: define IFQ_BYPASS_EN to hand a response straight to decode
// in its ack cycle when the queue is empty and decode is ready.
module ifetch_queue #(
    parameter int PCLEN = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PCLEN-1:0]         pc_in,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [PCLEN-1:0]         mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              instr,
    output logic [PCLEN-1:0]         instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      data_q [DEPTH];
    logic [PCLEN-1:0] pc_q   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [AW:0] occupancy;
    logic        has_room;
    logic        resp;
    logic        accept;
    logic        push;
    logic        q_pop;
    logic        bypass;

    // A request still outstanding has a slot reserved for its response.
    assign occupancy = count + {{AW{1'b0}}, (state == WAIT)};
    assign has_room  = occupancy < (AW+1)'(DEPTH);

    assign resp   = (state == WAIT) && mem_ack;
    assign accept = pc_valid && pc_ready;

`ifdef IFQ_BYPASS_EN
    assign bypass = resp && !flush && !reset && (count == '0) && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    // A flushed or bypassed response is never written into the queue.
    assign push  = resp && !flush && !bypass;
    assign q_pop = instr_ready && (count != '0);

    assign instr_valid = (count != '0) || bypass;
    assign instr       = bypass ? mem_rdata : data_q[rd_ptr];
    assign instr_pc    = bypass ? mem_addr  : pc_q[rd_ptr];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: track whether a request is outstanding and whether it was flushed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    state_next = accept ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (mem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory request level and PC-side readiness.
    always_comb begin
        mem_req  = (state != IDLE);
        pc_ready = !reset && !flush && has_room &&
                   ((state == IDLE) || ((state == WAIT) && mem_ack));
    end

    // Request address is captured on accept and held until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr <= '0;
        end else if (accept) begin
            mem_addr <= pc_in;
        end
    end

    // Occupancy and pointers; flush empties the queue at the end of the cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (q_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(q_pop);
        end
    end

    // Entry storage: response word and the address it was fetched from.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue (default build, DEPTH=4, PCLEN=32): directed scenarios
// followed by random traffic, all checked against a queue-based model.
module tb_ifetch_queue;

    localparam int PCLEN = 32;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [PCLEN-1:0]  pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              mem_req;
    logic [PCLEN-1:0]  mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [31:0]       instr;
    logic [PCLEN-1:0]  instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // model: FIFO of {pc, data}, one outstanding request that may be live or dropped
    logic [63:0] m_q[$];
    bit          m_live;
    bit          m_drop;
    logic [31:0] m_addr;
    bit          m_acc;
    bit          m_pop;
    logic [31:0] popped[$];

    ifetch_queue #(.PCLEN(PCLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model for the current inputs, then advance one clock.
    task automatic step();
        int free;
        bit exp_rdy;
        #2;
        free = DEPTH - m_q.size() - (m_live ? 1 : 0);
        exp_rdy = !reset && !flush && (free >= 1) &&
                  ((!m_live && !m_drop) || (m_live && mem_ack));
        chk("pc_ready", 64'(pc_ready), 64'(exp_rdy));
        chk("mem_req", 64'(mem_req), 64'(m_live || m_drop));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
        chk("count", 64'(count), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("instr", 64'(instr), 64'(m_q[0][31:0]));
            chk("instr_pc", 64'(instr_pc), 64'(m_q[0][63:32]));
        end
        m_acc = pc_valid && exp_rdy;
        m_pop = (m_q.size() != 0) && instr_ready;
        if (reset) begin
            m_q.delete();
            m_live = 0;
            m_drop = 0;
            m_addr = '0;
        end else begin
            if (m_pop) begin
                popped.push_back(instr_pc);
                void'(m_q.pop_front());
            end
            if (flush) begin
                m_q.delete();
                if (m_live) begin
                    m_drop = !mem_ack;
                    m_live = 0;
                end else if (m_drop && mem_ack) begin
                    m_drop = 0;
                end
            end else begin
                if (m_live && mem_ack) begin
                    m_q.push_back({m_addr, mem_rdata});
                    m_live = 0;
                end else if (m_drop && mem_ack) begin
                    m_drop = 0;
                end
                if (m_acc) begin
                    m_live = 1;
                    m_addr = pc_in;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; pc_valid = 0; flush = 0; mem_ack = 0; instr_ready = 0;
    endtask

    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        pc_valid = 1; pc_in = pc;
        step();
        pc_valid = 0; mem_ack = 1; mem_rdata = data;
        step();
        mem_ack = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (m_q.size() == 0 && !m_live && !m_drop) break;
            pc_valid = 0; instr_ready = 1; mem_ack = m_live || m_drop;
            mem_rdata = $urandom;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int nextpc;
        reset = 1; pc_valid = 0; flush = 0; mem_ack = 1; instr_ready = 0;
        pc_in = 32'h55; mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        m_live = 0; m_drop = 0; m_addr = '0;
        step();
        step();

        // reset, single fetch, ack two cycles after accept
        idle_inputs();
        pc_valid = 1; pc_in = 32'h10;
        step();
        pc_valid = 0;
        step();
        step();
        mem_ack = 1; mem_rdata = 32'h00500093;
        step();
        mem_ack = 0;
        chk("first_instr", 64'(instr), 64'h00500093);
        chk("first_instr_pc", 64'(instr_pc), 64'h10);
        chk("first_count", 64'(count), 64'd1);
        chk("first_valid", 64'(instr_valid), 64'd1);
        drain();

        // streaming with back-pressure, FIFO order across pointer wrap
        popped.delete();
        nextpc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            pc_valid = (nextpc < 8);
            pc_in = 32'(nextpc);
            mem_ack = m_live;
            mem_rdata = 32'hA5A50000 | 32'(nextpc);
            instr_ready = (cyc >= 12);
            step();
            if (m_acc) nextpc++;
            if (cyc == 11) begin
                chk("stream_full_count", 64'(count), 64'd4);
                chk("stream_full_ready", 64'(pc_ready), 64'd0);
            end
        end
        idle_inputs();
        chk("stream_popped_n", 64'(popped.size()), 64'd8);
        for (int i = 0; i < popped.size() && i < 8; i++)
            chk("stream_order", 64'(popped[i]), 64'(i));
        drain();

        // flush while waiting, late ack must be dropped
        pc_valid = 1; pc_in = 32'h40;
        step();
        flush = 1; pc_valid = 0;
        step();
        flush = 0; pc_valid = 1; pc_in = 32'h44;
        step();
        chk("drop_mem_req", 64'(mem_req), 64'd1);
        chk("drop_ready", 64'(pc_ready), 64'd0);
        step();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        chk("drop_ack_ready", 64'(pc_ready), 64'd0);
        step();
        mem_ack = 0; pc_valid = 0;
        chk("drop_after_count", 64'(count), 64'd0);
        chk("drop_after_valid", 64'(instr_valid), 64'd0);
        chk("drop_after_req", 64'(mem_req), 64'd0);
        drain();

        // flush with three queued entries and a same-cycle ack
        fetch_one(32'h80, 32'h11111111);
        fetch_one(32'h81, 32'h22222222);
        fetch_one(32'h82, 32'h33333333);
        pc_valid = 1; pc_in = 32'h100;
        step();
        pc_valid = 0; flush = 1; mem_ack = 1; mem_rdata = 32'h12345678;
        step();
        flush = 0; mem_ack = 0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(instr_valid), 64'd0);
        chk("flush_req", 64'(mem_req), 64'd0);
        drain();

        // ack + accept + pop together; then push + pop at DEPTH-1
        fetch_one(32'h180, 32'hAAAA0001);
        fetch_one(32'h181, 32'hAAAA0002);
        pc_valid = 1; pc_in = 32'h182;
        step();
        pc_in = 32'h200; mem_ack = 1; mem_rdata = 32'hAAAA0003; instr_ready = 1;
        step();
        chk("overlap_count", 64'(count), 64'd2);
        chk("overlap_req", 64'(mem_req), 64'd1);
        chk("overlap_addr", 64'(mem_addr), 64'h200);
        pc_valid = 0; instr_ready = 0; mem_rdata = 32'hAAAA0004;
        step();
        pc_valid = 1; pc_in = 32'h300; mem_ack = 0;
        step();
        pc_valid = 0; mem_ack = 1; mem_rdata = 32'hAAAA0005; instr_ready = 1;
        step();
        chk("full_pushpop_count", 64'(count), 64'd3);
        drain();

        // reset while waiting, ack after reset ignored
        pc_valid = 1; pc_in = 32'h500;
        step();
        pc_valid = 0; reset = 1;
        step();
        step();
        reset = 0; mem_ack = 1; mem_rdata = 32'h00000BAD;
        step();
        mem_ack = 0;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            pc_valid = ($urandom_range(9) < 6);
            pc_in = $urandom;
            flush = ($urandom_range(19) == 0);
            mem_ack = ($urandom_range(9) < 4);
            mem_rdata = $urandom;
            instr_ready = ($urandom_range(1) == 1);
            step();
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
